// File: rtl/jtframe_joyser.sv
// Serial reader for a 16-bit parallel-in shift-register joystick chain.
// Two consecutive agreeing scans are required before the player buses change.
module jtframe_joyser #(
    parameter int unsigned DIV = 8,
    parameter int unsigned GAP = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic [5:0] joy1,
    output logic [5:0] joy2,
    output logic       upd
);

    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
    localparam logic [15:0] LOAD_LAST = 16'(2 * DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  sync_q, sync_d;
    logic [11:0] scan_q, scan_d;
    logic [11:0] prev_q, prev_d;
    logic [11:0] out_q, out_d;
    logic        upd_q, upd_d;
    logic        jclk_q, jclk_d;
    logic        jload_q, jload_d;

    logic        bit_used;
    logic [3:0]  bit_pos;
    logic [11:0] cand;

    // Frame bits 6,7,14,15 are unused; the rest pack into a 12-bit scan word.
    assign bit_used = (idx_q[2:1] != 2'b11);
    assign bit_pos  = idx_q[3] ? (4'd6 + {1'b0, idx_q[2:0]}) : {1'b0, idx_q[2:0]};

    // Reorder up,down,left,right,fire1,fire2 into the joystick bus bit map.
    assign cand = {scan_q[11], scan_q[10], scan_q[6], scan_q[7], scan_q[8], scan_q[9],
                   scan_q[5],  scan_q[4],  scan_q[0], scan_q[1], scan_q[2], scan_q[3]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sync_d  = {sync_q[0], joy_data};
        scan_d  = scan_q;
        prev_d  = prev_q;
        out_d   = out_q;
        upd_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = SHIFT_LO;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    if (bit_used) begin
                        scan_d[bit_pos] = sync_q[1];
                    end
                    state_d = SHIFT_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                prev_d = cand;
                if (cand == prev_q) begin
                    out_d = cand;
                    upd_d = (cand != out_q);
                end
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Strobes follow the next state so they leave the flops glitch-free.
        jload_d = (state_d != LOAD);
        jclk_d  = (state_d != SHIFT_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sync_q  <= 2'b11;
            scan_q  <= 12'hFFF;
            prev_q  <= 12'hFFF;
            out_q   <= 12'hFFF;
            upd_q   <= 1'b0;
            jclk_q  <= 1'b1;
            jload_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync_q  <= sync_d;
            scan_q  <= scan_d;
            prev_q  <= prev_d;
            out_q   <= out_d;
            upd_q   <= upd_d;
            jclk_q  <= jclk_d;
            jload_q <= jload_d;
        end
    end

    assign joy_clk  = jclk_q;
    assign joy_load = jload_q;
    assign joy1     = out_q[5:0];
    assign joy2     = out_q[11:6];
    assign upd      = upd_q;

endmodule

// File: tb/tb_jtframe_joyser.sv
// Directed bench for jtframe_joyser: one instance at default timing, one at DIV=2/GAP=1,
// each fed by a behavioural 16-bit shift-register chain.
module tb_jtframe_joyser;

    localparam int GAP_A    = 256;
    localparam int PERIOD_A = 529;
    localparam int PERIOD_B = 70;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        joyDataA, joyClkA, joyLoadA, updA;
    logic [5:0]  joy1A, joy2A;
    logic [15:0] shregA = 16'hFFFF;
    logic [15:0] frameA = 16'hFFFF;

    logic        joyDataB, joyClkB, joyLoadB, updB;
    logic [5:0]  joy1B, joy2B;
    logic [15:0] shregB = 16'hFFFF;
    logic [15:0] frameB = 16'hA5A5;

    int total = 0;
    int bad = 0;
    int updCntA = 0;
    int updCntB = 0;
    int overlapCnt = 0;
    int cyc, loadLow, clkLow, clkFalls;

    always #5 clk = ~clk;

    jtframe_joyser #(.DIV(8), .GAP(256)) dutA (
        .clk(clk), .rst(rst), .joy_data(joyDataA), .joy_clk(joyClkA),
        .joy_load(joyLoadA), .joy1(joy1A), .joy2(joy2A), .upd(updA)
    );

    jtframe_joyser #(.DIV(2), .GAP(1)) dutB (
        .clk(clk), .rst(rst), .joy_data(joyDataB), .joy_clk(joyClkB),
        .joy_load(joyLoadB), .joy1(joy1B), .joy2(joy2B), .upd(updB)
    );

    // Chain models: parallel load while load is low, shift toward bit 0 on clock rise.
    always @(negedge joyLoadA or posedge joyClkA) begin
        if (!joyLoadA) shregA = frameA;
        else           shregA = {1'b1, shregA[15:1]};
    end
    assign joyDataA = shregA[0];

    always @(negedge joyLoadB or posedge joyClkB) begin
        if (!joyLoadB) begin
            shregB = frameB;
            frameB = ~frameB;
        end else begin
            shregB = {1'b1, shregB[15:1]};
        end
    end
    assign joyDataB = shregB[0];

    always @(negedge clk) begin
        if (updA) updCntA++;
        if (updB) updCntB++;
        if (!joyClkA && !joyLoadA) overlapCnt++;
        if (!joyClkB && !joyLoadB) overlapCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Queue the frame for the next scan, then run until joy_load next falls,
    // collecting cycle and strobe statistics over that window.
    task automatic applyStimulus(input logic [15:0] f);
        logic prevLoad, prevClk, fell;
        frameA   = f;
        cyc      = 0;
        loadLow  = 0;
        clkLow   = 0;
        clkFalls = 0;
        prevLoad = joyLoadA;
        prevClk  = joyClkA;
        fell     = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            cyc++;
            if (!joyLoadA) loadLow++;
            if (!joyClkA) clkLow++;
            if (prevClk && !joyClkA) clkFalls++;
            prevClk  = joyClkA;
            fell     = prevLoad && !joyLoadA;
            prevLoad = joyLoadA;
            if (fell) break;
        end
        if (!fell) checkOutput("load_timeout", 1, 0);
    endtask

    initial begin
        logic prevC, prevL, hit;
        int falls, n;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_clk", joyClkA, 1);
        checkOutput("rst_load", joyLoadA, 1);
        checkOutput("rst_joy1", joy1A, 6'h3F);
        checkOutput("rst_joy2", joy2A, 6'h3F);
        checkOutput("rst_upd", updA, 0);
        rst = 1'b0;
        updCntA = 0;
        updCntB = 0;
        overlapCnt = 0;

        // Load falls on the GAP-th edge after the last reset edge: GAP+1 edges inclusive.
        applyStimulus(16'hFFFF);
        checkOutput("first_load", cyc, GAP_A + 1);
        applyStimulus(16'hFFFF);
        checkOutput("period", cyc, PERIOD_A);
        checkOutput("load_low", loadLow, 16);
        checkOutput("clk_low", clkLow, 128);
        checkOutput("clk_pulses", clkFalls, 16);
        checkOutput("idle_joy1", joy1A, 6'h3F);
        checkOutput("idle_joy2", joy2A, 6'h3F);
        checkOutput("idle_upd", updCntA, 0);

        applyStimulus(16'hFFFE);
        applyStimulus(16'hFFFE);
        checkOutput("up1_joy1", joy1A, 6'h3F);
        checkOutput("up1_upd", updCntA, 0);
        applyStimulus(16'hDFFE);
        checkOutput("up2_joy1", joy1A, 6'h37);
        checkOutput("up2_joy2", joy2A, 6'h3F);
        checkOutput("up2_upd", updCntA, 1);
        applyStimulus(16'hFFFE);
        checkOutput("glitch_joy2", joy2A, 6'h3F);
        checkOutput("glitch_joy1", joy1A, 6'h37);
        checkOutput("glitch_upd", updCntA, 1);

        applyStimulus(16'h7FBE);
        applyStimulus(16'h7FBE);
        applyStimulus(16'h7FBE);
        applyStimulus(16'hFFF7);
        checkOutput("ign_joy1", joy1A, 6'h37);
        checkOutput("ign_joy2", joy2A, 6'h3F);
        checkOutput("ign_upd", updCntA, 1);

        // Abort the P1-right scan during the low phase of bit 7.
        falls = 0;
        prevC = joyClkA;
        for (int i = 0; i < 400 && falls < 8; i++) begin
            @(negedge clk);
            if (prevC && !joyClkA) falls++;
            prevC = joyClkA;
        end
        if (falls < 8) checkOutput("lo7_timeout", 1, 0);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_clk", joyClkA, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_clk", joyClkA, 1);
        checkOutput("mid_rst_load", joyLoadA, 1);
        checkOutput("mid_rst_joy1", joy1A, 6'h3F);
        checkOutput("mid_rst_joy2", joy2A, 6'h3F);
        checkOutput("mid_rst_upd", updA, 0);
        rst = 1'b0;
        updCntA = 0;
        updCntB = 0;

        applyStimulus(16'hFFF7);
        checkOutput("rst_to_load", cyc, GAP_A + 1);
        applyStimulus(16'hFFF7);
        checkOutput("r1_joy1", joy1A, 6'h3F);
        checkOutput("r1_upd", updCntA, 0);
        applyStimulus(16'hFFF7);
        checkOutput("r2_joy1", joy1A, 6'h3E);
        checkOutput("r2_joy2", joy2A, 6'h3F);
        checkOutput("r2_upd", updCntA, 1);

        // Fast instance: alternating frames must never pass the filter.
        prevL = joyLoadB;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = prevL && !joyLoadB;
            prevL = joyLoadB;
        end
        if (!hit) checkOutput("b_timeout", 1, 0);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                n++;
                hit = prevL && !joyLoadB;
                prevL = joyLoadB;
            end
            checkOutput("b_period", n, PERIOD_B);
        end
        checkOutput("b_joy1", joy1B, 6'h3F);
        checkOutput("b_joy2", joy2B, 6'h3F);
        checkOutput("b_upd", updCntB, 0);
        checkOutput("overlap", overlapCnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
